// File: rtl/dly_lane_loader.sv
// dly_lane_loader
// Delay-programming sequencer for one DDR3 byte lane. Holds output and input
// delay values for every delay element of the lane (DQ0..DQ7, DM, DQS) and, on
// request, walks through the elements one per cycle on the shared dly_data bus
// with per-element set strobes, then applies all masked elements together with
// a single ld strobe, waits for the delay lines to settle and reports done.
//
// Ports
//   clk_div     clock shared with the delay pipes
//   rst_n       synchronous active-low reset
//   tbl_we      table write strobe
//   tbl_addr    {dir, idx[3:0]}; dir 1 = output delay, 0 = input delay
//   tbl_wdata   table write value
//   tbl_rdata   registered table read (write-through on same-address write)
//   req         load request (level, sampled only when idle)
//   req_dir     1 = program ODELAYs, 0 = IDELAYs
//   req_mask    elements to program
//   ack         one-cycle pulse: request accepted
//   busy        operation in progress (through the done cycle)
//   done        one-cycle pulse: delays applied and settled
//   dly_data    shared delay value bus, 0 outside the set phase
//   set_odelay  per-element value-latch strobes, output direction
//   set_idelay  per-element value-latch strobes, input direction
//   ld_odelay   per-element apply strobes, output direction
//   ld_idelay   per-element apply strobes, input direction
//
// state  | meaning
// IDLE   | waiting for req
// SET    | one element per cycle on dly_data with its set strobe
// LD     | one-cycle simultaneous apply of all masked elements
// SETTLE | down-counter wait for the delay lines to settle
// DONE   | one-cycle done pulse, busy still high
module dly_lane_loader #(
    parameter int NUM_DLY       = 10,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk_div,
    input  logic               rst_n,
    input  logic               tbl_we,
    input  logic [4:0]         tbl_addr,
    input  logic [7:0]         tbl_wdata,
    output logic [7:0]         tbl_rdata,
    input  logic               req,
    input  logic               req_dir,
    input  logic [NUM_DLY-1:0] req_mask,
    output logic               ack,
    output logic               busy,
    output logic               done,
    output logic [7:0]         dly_data,
    output logic [NUM_DLY-1:0] set_odelay,
    output logic [NUM_DLY-1:0] set_idelay,
    output logic [NUM_DLY-1:0] ld_odelay,
    output logic [NUM_DLY-1:0] ld_idelay
);

    localparam logic [3:0] LAST_IDX    = 4'(NUM_DLY - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET,
        S_LD,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         settle_q, settle_d;
    logic               dir_q, dir_d;
    logic [NUM_DLY-1:0] mask_q, mask_d;

    logic [7:0]         tbl_out [NUM_DLY];
    logic [7:0]         tbl_in  [NUM_DLY];

    logic               ack_d, busy_d, done_d;
    logic [7:0]         dly_data_d;
    logic [7:0]         rdata_d;
    logic [NUM_DLY-1:0] set_vec;
    logic [NUM_DLY-1:0] set_o_d, set_i_d, ld_o_d, ld_i_d;

    // ---------------- delay table ----------------
    // Out-of-range indices match no entry, so such writes are dropped.
    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DLY; i++) begin
                tbl_out[i] <= '0;
                tbl_in[i]  <= '0;
            end
        end else if (tbl_we) begin
            for (int i = 0; i < NUM_DLY; i++) begin
                if (tbl_addr[3:0] == 4'(i)) begin
                    if (tbl_addr[4]) tbl_out[i] <= tbl_wdata;
                    else             tbl_in[i]  <= tbl_wdata;
                end
            end
        end
    end

    // Read port forwards a same-cycle write so software sees its data at once.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NUM_DLY; i++) begin
            if (tbl_addr[3:0] == 4'(i)) begin
                if (tbl_we)           rdata_d = tbl_wdata;
                else if (tbl_addr[4]) rdata_d = tbl_out[i];
                else                  rdata_d = tbl_in[i];
            end
        end
    end

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            dir_q    <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            dir_q    <= dir_d;
            mask_q   <= mask_d;
        end
    end

    // ---------------- next state and next outputs ----------------
    // Outputs are registered, so they are derived from the next state: the
    // values latched on an edge describe the cycle that edge starts.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        ack_d      = 1'b0;
        dly_data_d = '0;
        set_vec    = '0;
        set_o_d    = '0;
        set_i_d    = '0;
        ld_o_d     = '0;
        ld_i_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    dir_d   = req_dir;
                    mask_d  = req_mask;
                    idx_d   = '0;
                    ack_d   = 1'b1;
                    state_d = S_SET;
                end
            end
            S_SET: begin
                if (idx_q == LAST_IDX) state_d = S_LD;
                else                   idx_d   = idx_q + 4'd1;
            end
            S_LD: begin
                settle_d = SETTLE_LOAD;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == 4'd0) state_d  = S_DONE;
                else                  settle_d = settle_q - 4'd1;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);

        if (state_d == S_SET) begin
            for (int i = 0; i < NUM_DLY; i++) begin
                if (idx_d == 4'(i)) begin
                    dly_data_d = dir_d ? tbl_out[i] : tbl_in[i];
                    set_vec[i] = mask_d[i];
                end
            end
            if (dir_d) set_o_d = set_vec;
            else       set_i_d = set_vec;
        end

        if (state_d == S_LD) begin
            if (dir_d) ld_o_d = mask_d;
            else       ld_i_d = mask_d;
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            tbl_rdata  <= '0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dly_data   <= '0;
            set_odelay <= '0;
            set_idelay <= '0;
            ld_odelay  <= '0;
            ld_idelay  <= '0;
        end else begin
            tbl_rdata  <= rdata_d;
            ack        <= ack_d;
            busy       <= busy_d;
            done       <= done_d;
            dly_data   <= dly_data_d;
            set_odelay <= set_o_d;
            set_idelay <= set_i_d;
            ld_odelay  <= ld_o_d;
            ld_idelay  <= ld_i_d;
        end
    end

endmodule

// File: tb/tb_dly_lane_loader.sv
module tb_dly_lane_loader;

    localparam int N      = 10;
    localparam int S      = 4;
    localparam int DONE_P = N + 2 + S;   // cycles from accept edge to done

    logic         clk;
    logic         rst_n;
    logic         tbl_we;
    logic [4:0]   tbl_addr;
    logic [7:0]   tbl_wdata;
    logic [7:0]   tbl_rdata;
    logic         req;
    logic         req_dir;
    logic [N-1:0] req_mask;
    logic         ack, busy, done;
    logic [7:0]   dly_data;
    logic [N-1:0] set_odelay, set_idelay, ld_odelay, ld_idelay;

    int errors = 0;
    int checks = 0;

    dly_lane_loader #(.NUM_DLY(N), .SETTLE_CYCLES(S)) dut (
        .clk_div   (clk),
        .rst_n     (rst_n),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .tbl_rdata (tbl_rdata),
        .req       (req),
        .req_dir   (req_dir),
        .req_mask  (req_mask),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .dly_data  (dly_data),
        .set_odelay(set_odelay),
        .set_idelay(set_idelay),
        .ld_odelay (ld_odelay),
        .ld_idelay (ld_idelay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An operation is tracked purely as "cycles since the accept edge"; every
    // output follows from that number plus the captured dir/mask and the table.
    int           phase = 0;
    logic         m_dir = 1'b0;
    logic [N-1:0] m_mask = '0;
    logic [7:0]   m_out [N];
    logic [7:0]   m_in  [N];
    logic         e_ack = 0, e_busy = 0, e_done = 0;
    logic [7:0]   e_dly = 0, e_rdata = 0;
    logic [N-1:0] e_set_o = 0, e_set_i = 0, e_ld_o = 0, e_ld_i = 0;

    always @(posedge clk) begin
        int idx;
        int k;
        idx = int'(tbl_addr[3:0]);
        if (!rst_n) begin
            phase = 0;
            for (int i = 0; i < N; i++) begin
                m_out[i] = 8'h00;
                m_in[i]  = 8'h00;
            end
            e_rdata = 8'h00;
        end else begin
            if (idx >= N)    e_rdata = 8'h00;
            else if (tbl_we) e_rdata = tbl_wdata;
            else             e_rdata = tbl_addr[4] ? m_out[idx] : m_in[idx];

            if (phase == 0) begin
                if (req) begin
                    phase  = 1;
                    m_dir  = req_dir;
                    m_mask = req_mask;
                end
            end else if (phase == DONE_P) begin
                phase = 0;
            end else begin
                phase = phase + 1;
            end
        end

        e_ack   = (phase == 1);
        e_busy  = (phase != 0);
        e_done  = (phase == DONE_P);
        e_dly   = 8'h00;
        e_set_o = '0;
        e_set_i = '0;
        e_ld_o  = '0;
        e_ld_i  = '0;
        if (phase >= 1 && phase <= N) begin
            k     = phase - 1;
            e_dly = m_dir ? m_out[k] : m_in[k];
            if (m_mask[k]) begin
                if (m_dir) e_set_o = N'(1) << k;
                else       e_set_i = N'(1) << k;
            end
        end
        if (phase == N + 1) begin
            if (m_dir) e_ld_o = m_mask;
            else       e_ld_i = m_mask;
        end

        // Table write lands after the read above: the bus shows the old value.
        if (rst_n && tbl_we && idx < N) begin
            if (tbl_addr[4]) m_out[idx] = tbl_wdata;
            else             m_in[idx]  = tbl_wdata;
        end
    end

    always @(negedge clk) begin
        check("ack",        32'(ack),        32'(e_ack));
        check("busy",       32'(busy),       32'(e_busy));
        check("done",       32'(done),       32'(e_done));
        check("dly_data",   32'(dly_data),   32'(e_dly));
        check("set_odelay", 32'(set_odelay), 32'(e_set_o));
        check("set_idelay", 32'(set_idelay), 32'(e_set_i));
        check("ld_odelay",  32'(ld_odelay),  32'(e_ld_o));
        check("ld_idelay",  32'(ld_idelay),  32'(e_ld_i));
        check("tbl_rdata",  32'(tbl_rdata),  32'(e_rdata));
    end

    // ---------------- directed stimulus ----------------
    // All tasks start and end just after a falling edge.
    task automatic tbl_write(input logic [4:0] a, input logic [7:0] d);
        tbl_we    = 1'b1;
        tbl_addr  = a;
        tbl_wdata = d;
        @(negedge clk);
        tbl_we    = 1'b0;
    endtask

    task automatic fill_table();
        for (int k = 0; k < N; k++) begin
            tbl_write(5'(16 + k), 8'(8'h10 + k));
            tbl_write(5'(k),      8'(8'h40 + k));
        end
    endtask

    // Leaves the bench in cycle t0+1 (the ack cycle).
    task automatic start_req(input logic dir, input logic [N-1:0] mask);
        req      = 1'b1;
        req_dir  = dir;
        req_mask = mask;
        @(negedge clk);
        req      = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_data"}, 32'(dly_data), 32'd0);
        check({tag, "_set"},  32'({set_odelay, set_idelay}), 32'd0);
        check({tag, "_ld"},   32'({ld_odelay, ld_idelay}), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;
        req       = 1'b0;
        req_dir   = 1'b0;
        req_mask  = '0;
        repeat (3) @(negedge clk);
        check_quiet("por");
        rst_n = 1'b1;
        @(negedge clk);

        // reset clears the table
        fill_table();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_quiet("rst");
        for (int a = 0; a < 32; a++) begin
            tbl_addr = 5'(a);
            @(negedge clk);
            check("rst_tbl_zero", 32'(tbl_rdata), 32'd0);
        end

        // table reads, out-of-range write ignored
        fill_table();
        tbl_write(5'h1A, 8'hEE);
        tbl_addr = 5'h1A;
        @(negedge clk);
        check("rd_oob", 32'(tbl_rdata), 32'd0);
        tbl_addr = 5'h12;
        @(negedge clk);
        check("rd_out2", 32'(tbl_rdata), 32'h12);
        tbl_addr = 5'h09;
        @(negedge clk);
        check("rd_in9", 32'(tbl_rdata), 32'h49);

        // full ODELAY load
        start_req(1'b1, 10'h3FF);
        for (int s = 1; s <= 17; s++) begin
            if (s == 1)  check("odly_ack", 32'(ack), 32'd1);
            if (s == 4) begin
                check("odly_k3_data", 32'(dly_data), 32'h13);
                check("odly_k3_set",  32'(set_odelay), 32'h008);
            end
            if (s == 11) check("odly_ld", 32'(ld_odelay), 32'h3FF);
            if (s == 15) check("odly_done_early", 32'(done), 32'd0);
            if (s == 16) check("odly_done", 32'(done), 32'd1);
            @(negedge clk);
        end

        // sparse IDELAY mask
        start_req(1'b0, 10'h201);
        for (int s = 1; s <= 17; s++) begin
            if (s == 1) check("sp_set0", 32'(set_idelay), 32'h001);
            if (s == 5) begin
                check("sp_k4_data", 32'(dly_data), 32'h44);
                check("sp_k4_set",  32'(set_idelay), 32'h000);
            end
            if (s == 10) check("sp_set9", 32'(set_idelay), 32'h200);
            if (s == 11) check("sp_ld", 32'(ld_idelay), 32'h201);
            @(negedge clk);
        end

        // table write during the set phase: bus keeps old value
        start_req(1'b0, 10'h3FF);
        for (int s = 1; s <= 17; s++) begin
            if (s == 4) begin
                check("wr_old_on_bus", 32'(dly_data), 32'h43);
                tbl_we    = 1'b1;
                tbl_addr  = 5'h03;
                tbl_wdata = 8'hA5;
            end
            if (s == 5) begin
                tbl_we = 1'b0;
                check("wr_rdata_new", 32'(tbl_rdata), 32'hA5);
                check("wr_next_data", 32'(dly_data), 32'h44);
            end
            @(negedge clk);
        end

        // zero mask with req held high: accepts at t0 and t0+17 only
        req      = 1'b1;
        req_dir  = 1'b1;
        req_mask = '0;
        @(negedge clk);
        for (int s = 1; s <= 35; s++) begin
            if (s == 5)  check("z_no_set", 32'(set_odelay), 32'd0);
            if (s == 11) check("z_no_ld", 32'(ld_odelay), 32'd0);
            if (s == 16) check("z_done", 32'(done), 32'd1);
            if (s == 17) check("z_no_ack_gap", 32'(ack), 32'd0);
            if (s == 18) begin
                check("z_reaccept", 32'(ack), 32'd1);
                req = 1'b0;
            end
            @(negedge clk);
        end

        // reset mid-operation aborts without ld/done
        start_req(1'b1, 10'h3FF);
        for (int s = 1; s <= 25; s++) begin
            if (s == 6) rst_n = 1'b0;
            if (s == 7) begin
                rst_n = 1'b1;
                check_quiet("abort");
            end
            if (s == 11) check("abort_no_ld", 32'(ld_odelay), 32'd0);
            if (s == 16) check("abort_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end

        // recovery run after the abort
        tbl_write(5'h12, 8'h77);
        start_req(1'b1, 10'h004);
        for (int s = 1; s <= 17; s++) begin
            if (s == 3) begin
                check("rec_data", 32'(dly_data), 32'h77);
                check("rec_set",  32'(set_odelay), 32'h004);
            end
            if (s == 11) check("rec_ld", 32'(ld_odelay), 32'h004);
            if (s == 16) check("rec_done", 32'(done), 32'd1);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dly_lane_loader.md
# dly_lane_loader

Delay-programming sequencer for one DDR3 byte lane of the PHY. Holds a table of 8-bit output and input delay values for every delay element in the lane (DQ0..DQ7, DM, DQS), and on request streams the selected values over a shared `dly_data` bus. It pulses per-element `set_*` strobes, then issues one simultaneous `ld_*` so all masked elements switch delay on the same `clk_div` edge. Sits between the sequencer/command register interface and the `odelay_fine_pipe`/`idelay_fine_pipe` instances of the lane.

## Interface
Parameters:
- `NUM_DLY`, 10 — delay elements per lane; index 0..7 = DQ, 8 = DM, 9 = DQS.
- `SETTLE_CYCLES`, 4 — cycles waited after the `ld` pulse before `done` (range 1..15).

Ports:
- `clk_div` in 1 — the single clock, same clock as the delay pipes.
- `rst_n` in 1 — reset; synchronous, active-low.
- `tbl_we` in 1 — table write strobe.
- `tbl_addr` in 5 — {dir, idx[3:0]}; dir 1 = output delay, 0 = input delay.
- `tbl_wdata` in 8 — table write value.
- `tbl_rdata` out 8 — table[tbl_addr], registered (1-cycle latency).
- `req` in 1 — load request, level; sampled only when idle.
- `req_dir` in 1 — 1 = program ODELAYs, 0 = IDELAYs.
- `req_mask` in NUM_DLY — elements to program.
- `ack` out 1 — one-cycle pulse: request accepted, `req_dir`/`req_mask` captured.
- `busy` out 1 — operation in progress.
- `done` out 1 — one-cycle pulse: new delays applied and settled.
- `dly_data` out 8 — shared delay value bus.
- `set_odelay`, `set_idelay` out NUM_DLY each — per-element value-latch strobes.
- `ld_odelay`, `ld_idelay` out NUM_DLY each — per-element apply strobes.

## Operation
- Table: 2×NUM_DLY × 8-bit registers, all cleared by reset. Writes with idx ≥ NUM_DLY are ignored; reads of those addresses return 0. Writes are allowed while busy. A write to an entry in the same cycle the FSM reads it drives the old value.
- FSM states: IDLE, SET, LD, SETTLE, DONE.
  - IDLE: if `req`=1, capture `req_dir` and `req_mask`, clear the index counter, and go to SET.
  - SET: runs for exactly NUM_DLY cycles, one per index k = 0..NUM_DLY-1. `dly_data` = table[dir][k]. `set_<dir>[k]` = mask[k]. Unmasked indices still consume a cycle, which keeps latency deterministic.
  - LD: one cycle. `ld_<dir>[k]` = mask[k] for all k simultaneously.
  - SETTLE: counts SETTLE_CYCLES cycles.
  - DONE: one cycle, then IDLE.
- Only the selected direction's strobes ever assert. The other direction's vectors stay 0.
- `dly_data` is 0 whenever not in SET.
- At most one bit of `set_*` is high in any cycle.
- An all-zero mask runs the full sequence with no set/ld strobes. `ack`, `busy` and `done` behave normally.
- `req` while busy is ignored. It is not queued.
- All outputs are registered.

## Timing
- Let edge t0 sample `req`=1 in IDLE.
- `ack`=1 and `busy`=1 in cycle t0+1.
- SET occupies cycles t0+1 .. t0+NUM_DLY. Index k appears in cycle t0+1+k.
- LD is cycle t0+NUM_DLY+1.
- SETTLE occupies cycles t0+NUM_DLY+2 .. t0+NUM_DLY+1+SETTLE_CYCLES.
- `done`=1 in cycle t0+NUM_DLY+2+SETTLE_CYCLES. With the defaults this is t0+16.
- `busy` stays high through the done cycle. A `req` in the done cycle is ignored. The earliest next accept samples on the edge ending the first cycle after `done`.
- Reset values: every output 0, state IDLE, counters 0, table 0.
- Reset mid-operation takes effect on the next edge. The sequence aborts and no `ld` or `done` is issued. Elements that already received `set` keep their latched value, but it is not applied.
- `tbl_rdata` reflects `tbl_addr` (and any write) from the previous edge.

## Test plan
- Reset: write entries, then pulse `rst_n`=0 for 1 cycle -> all outputs 0, and `tbl_rdata` = 0 for every address.
- Full ODELAY load: table out[k] = 0x10+k, `req_dir`=1, mask 0x3FF, req at t0 -> `set_odelay[k]` with `dly_data` = 0x10+k in cycle t0+1+k; `ld_odelay` = 0x3FF in t0+11; `done` in t0+16; `set_idelay`/`ld_idelay` always 0.
- Sparse IDELAY mask 0x201 (DQ0, DQS) -> `set_idelay[0]` at t0+1 and `set_idelay[9]` at t0+10 only; `ld_idelay` = 0x201 at t0+11; `dly_data` is still driven with table values for every index.
- Boundary: mask 0 -> no strobes, `done` at t0+16. `req` held high continuously -> accepts at t0 and t0+17, with no `ack` in between. A table write to in[3] during cycle t0+4 -> old value on the bus, new value on `tbl_rdata` the next cycle.
- Reset asserted in cycle t0+6 -> from t0+7 all outputs 0 and no `ld`/`done`; a new request after release runs the full sequence correctly.
